// File: rtl/control_unit_if.sv
// Control/status bundle between the control_unit sequencer and the Mini SRC datapath.
// master = sequencer side (drives strobes), slave = datapath side (drives IR and CON).
interface control_unit_if #(
   parameter int OP_W = 5
);
   // Strobes are levels with no handshake: each is valid for the whole state and
   // takes effect in the datapath on the rising edge that ends that state.
   logic [31:0]     IR_Data;
   logic            CON_out;
   logic            PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
   logic            PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
   logic            Read, Write;
   logic            Gra, Grb, Grc, Rin, Rout, BAout;
   logic [OP_W-1:0] alu_instruction_bits;
   logic            run;

   modport master (
      input  IR_Data, CON_out,
      output PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
      output PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
      output Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, alu_instruction_bits, run
   );

   modport slave (
      output IR_Data, CON_out,
      input  PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
      input  PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
      input  Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, alu_instruction_bits, run
   );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the Mini SRC datapath: fetch T0-T2,
// opcode-specific execute T3-T7, HALT parks until clr.
module control_unit #(
   parameter int OP_W = 5
) (
   input  logic           clk,
   input  logic           clr,
   control_unit_if.master bus,
   output logic [3:0]     state_o
);
   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   localparam logic [OP_W-1:0] OP_LD   = OP_W'(0);
   localparam logic [OP_W-1:0] OP_LDI  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ST   = OP_W'(2);
   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_SHL  = OP_W'(11);
   localparam logic [OP_W-1:0] OP_ADDI = OP_W'(12);
   localparam logic [OP_W-1:0] OP_ORI  = OP_W'(14);
   localparam logic [OP_W-1:0] OP_DIV  = OP_W'(15);
   localparam logic [OP_W-1:0] OP_MUL  = OP_W'(16);
   localparam logic [OP_W-1:0] OP_NEG  = OP_W'(17);
   localparam logic [OP_W-1:0] OP_NOT  = OP_W'(18);
   localparam logic [OP_W-1:0] OP_IN   = OP_W'(22);
   localparam logic [OP_W-1:0] OP_OUT  = OP_W'(23);
   localparam logic [OP_W-1:0] OP_MFHI = OP_W'(24);
   localparam logic [OP_W-1:0] OP_MFLO = OP_W'(25);
   localparam logic [OP_W-1:0] OP_HALT = OP_W'(27);

   state_t          state_q, state_d;
   logic [OP_W-1:0] opcode;
   logic            is_reg_alu, is_imm, is_negnot, is_muldiv;
   logic            is_ld, is_ldi, is_st, is_addr, is_multi;
   logic            is_in, is_out, is_mfhi, is_mflo, is_halt;
   logic            unused_inputs;

   assign opcode     = bus.IR_Data[31 -: OP_W];
   assign is_reg_alu = (opcode >= OP_ADD) && (opcode <= OP_SHL);
   assign is_imm     = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
   assign is_negnot  = (opcode == OP_NEG) || (opcode == OP_NOT);
   assign is_muldiv  = (opcode == OP_DIV) || (opcode == OP_MUL);
   assign is_ld      = (opcode == OP_LD);
   assign is_ldi     = (opcode == OP_LDI);
   assign is_st      = (opcode == OP_ST);
   assign is_in      = (opcode == OP_IN);
   assign is_out     = (opcode == OP_OUT);
   assign is_mfhi    = (opcode == OP_MFHI);
   assign is_mflo    = (opcode == OP_MFLO);
   assign is_halt    = (opcode == OP_HALT);
   // ld, ldi and st share the base+offset address computation in T3-T4
   assign is_addr    = is_ld || is_ldi || is_st;
   assign is_multi   = is_reg_alu || is_imm || is_negnot || is_muldiv || is_addr;

   // No branch instructions in this revision, so CON and the operand fields are unused.
   assign unused_inputs = ^{bus.CON_out, bus.IR_Data[31-OP_W:0]};
   assign state_o       = state_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= S_RST;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST:  state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   state_d = S_T2;
         S_T2:   state_d = S_T3;
         S_T3: begin
            if (is_halt)       state_d = S_HALT;
            else if (is_multi) state_d = S_T4;
            else               state_d = S_T0;
         end
         S_T4:   state_d = is_negnot ? S_T0 : S_T5;
         S_T5:   state_d = (is_muldiv || is_ld || is_st) ? S_T6 : S_T0;
         S_T6:   state_d = (is_ld || is_st) ? S_T7 : S_T0;
         S_T7:   state_d = S_T0;
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   always_comb begin
      bus.PC_in = 1'b0;      bus.IR_in = 1'b0;      bus.Y_in = 1'b0;
      bus.Z_in = 1'b0;       bus.HI_in = 1'b0;      bus.LO_in = 1'b0;
      bus.MAR_in = 1'b0;     bus.MDR_in = 1'b0;     bus.OutPort_in = 1'b0;
      bus.IncPC = 1'b0;      bus.PC_out = 1'b0;     bus.Zhigh_out = 1'b0;
      bus.Zlow_out = 1'b0;   bus.HI_out = 1'b0;     bus.LO_out = 1'b0;
      bus.MDR_out = 1'b0;    bus.InPort_out = 1'b0; bus.C_out = 1'b0;
      bus.Read = 1'b0;       bus.Write = 1'b0;      bus.Gra = 1'b0;
      bus.Grb = 1'b0;        bus.Grc = 1'b0;        bus.Rin = 1'b0;
      bus.Rout = 1'b0;       bus.BAout = 1'b0;
      bus.alu_instruction_bits = '0;
      bus.run = (state_q != S_HALT);
      case (state_q)
         S_T0: begin
            bus.PC_out = 1'b1; bus.MAR_in = 1'b1; bus.IncPC = 1'b1; bus.Z_in = 1'b1;
         end
         S_T1: begin
            bus.Zlow_out = 1'b1; bus.PC_in = 1'b1; bus.Read = 1'b1; bus.MDR_in = 1'b1;
         end
         S_T2: begin
            bus.MDR_out = 1'b1; bus.IR_in = 1'b1;
         end
         S_T3: begin
            if (is_reg_alu || is_imm) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Y_in = 1'b1;
            end else if (is_negnot) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Z_in = 1'b1;
               bus.alu_instruction_bits = opcode;
            end else if (is_muldiv) begin
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Y_in = 1'b1;
            end else if (is_addr) begin
               bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Y_in = 1'b1;
            end else if (is_in) begin
               bus.InPort_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else if (is_out) begin
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPort_in = 1'b1;
            end else if (is_mfhi) begin
               bus.HI_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else if (is_mflo) begin
               bus.LO_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end
         end
         S_T4: begin
            if (is_reg_alu) begin
               bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Z_in = 1'b1;
               bus.alu_instruction_bits = opcode;
            end else if (is_imm) begin
               bus.C_out = 1'b1; bus.Z_in = 1'b1;
               bus.alu_instruction_bits = opcode;
            end else if (is_negnot) begin
               bus.Zlow_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else if (is_muldiv) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Z_in = 1'b1;
               bus.alu_instruction_bits = opcode;
            end else if (is_addr) begin
               bus.C_out = 1'b1; bus.Z_in = 1'b1;
               bus.alu_instruction_bits = OP_ADD;
            end
         end
         S_T5: begin
            if (is_reg_alu || is_imm || is_ldi) begin
               bus.Zlow_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else if (is_muldiv) begin
               bus.Zlow_out = 1'b1; bus.LO_in = 1'b1;
            end else if (is_ld || is_st) begin
               bus.Zlow_out = 1'b1; bus.MAR_in = 1'b1;
            end
         end
         S_T6: begin
            if (is_muldiv) begin
               bus.Zhigh_out = 1'b1; bus.HI_in = 1'b1;
            end else if (is_ld) begin
               bus.Read = 1'b1; bus.MDR_in = 1'b1;
            end else if (is_st) begin
               // Read stays low so MDR captures the register value from the bus
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDR_in = 1'b1;
            end
         end
         S_T7: begin
            if (is_ld) begin
               bus.MDR_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else if (is_st) begin
               bus.Write = 1'b1;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a behavioural Mini SRC datapath reacts to the strobes while
// per-instruction step tables predict the control word of every cycle.
module tb_control_unit;
   localparam int W    = 32;
   localparam int NREG = 16;
   localparam int MEMW = 512;

   // Control word layout: {run, alu[4:0], 26 strobes}
   localparam logic [W-1:0] RUN        = 32'h8000_0000;
   localparam logic [W-1:0] M_PC_IN    = 32'd1 << 0;
   localparam logic [W-1:0] M_IR_IN    = 32'd1 << 1;
   localparam logic [W-1:0] M_Y_IN     = 32'd1 << 2;
   localparam logic [W-1:0] M_Z_IN     = 32'd1 << 3;
   localparam logic [W-1:0] M_HI_IN    = 32'd1 << 4;
   localparam logic [W-1:0] M_LO_IN    = 32'd1 << 5;
   localparam logic [W-1:0] M_MAR_IN   = 32'd1 << 6;
   localparam logic [W-1:0] M_MDR_IN   = 32'd1 << 7;
   localparam logic [W-1:0] M_OUTP_IN  = 32'd1 << 8;
   localparam logic [W-1:0] M_INCPC    = 32'd1 << 9;
   localparam logic [W-1:0] M_PC_OUT   = 32'd1 << 10;
   localparam logic [W-1:0] M_ZHI_OUT  = 32'd1 << 11;
   localparam logic [W-1:0] M_ZLO_OUT  = 32'd1 << 12;
   localparam logic [W-1:0] M_HI_OUT   = 32'd1 << 13;
   localparam logic [W-1:0] M_LO_OUT   = 32'd1 << 14;
   localparam logic [W-1:0] M_MDR_OUT  = 32'd1 << 15;
   localparam logic [W-1:0] M_INP_OUT  = 32'd1 << 16;
   localparam logic [W-1:0] M_C_OUT    = 32'd1 << 17;
   localparam logic [W-1:0] M_READ     = 32'd1 << 18;
   localparam logic [W-1:0] M_WRITE    = 32'd1 << 19;
   localparam logic [W-1:0] M_GRA      = 32'd1 << 20;
   localparam logic [W-1:0] M_GRB      = 32'd1 << 21;
   localparam logic [W-1:0] M_GRC      = 32'd1 << 22;
   localparam logic [W-1:0] M_RIN      = 32'd1 << 23;
   localparam logic [W-1:0] M_ROUT     = 32'd1 << 24;
   localparam logic [W-1:0] M_BAOUT    = 32'd1 << 25;
   localparam logic [W-1:0] F0 = RUN | M_PC_OUT | M_MAR_IN | M_INCPC | M_Z_IN;
   localparam logic [W-1:0] F1 = RUN | M_ZLO_OUT | M_PC_IN | M_READ | M_MDR_IN;
   localparam logic [W-1:0] F2 = RUN | M_MDR_OUT | M_IR_IN;
   localparam logic [31:0]  NOP_WORD = 32'hD000_0000;
   localparam logic [31:0]  IN_PORT  = 32'hA5A5_0001;

   logic       clk, clr, con_r, load_init;
   logic [3:0] state_dbg;
   int         checks, errors;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_w;

   // Behavioural datapath state and its preload image
   logic [31:0] r [NREG];
   logic [31:0] r_init [NREG];
   logic [31:0] mem [MEMW];
   logic [31:0] mem_init [MEMW];
   logic [31:0] pc, ir, mar, mdr, y, hi, lo, hi_init, lo_init, bus_v;
   logic [63:0] z;
   logic [3:0]  sel;

   control_unit_if #(.OP_W(5)) cif ();

   control_unit #(.OP_W(5)) dut (
      .clk     (clk),
      .clr     (clr),
      .bus     (cif.master),
      .state_o (state_dbg)
   );

   assign cif.IR_Data = ir;
   assign cif.CON_out = con_r;
   assign obs_w = {cif.run, cif.alu_instruction_bits, cif.BAout, cif.Rout, cif.Rin, cif.Grc,
                   cif.Grb, cif.Gra, cif.Write, cif.Read, cif.C_out, cif.InPort_out, cif.MDR_out,
                   cif.LO_out, cif.HI_out, cif.Zlow_out, cif.Zhigh_out, cif.PC_out, cif.IncPC,
                   cif.OutPort_in, cif.MDR_in, cif.MAR_in, cif.LO_in, cif.HI_in, cif.Z_in,
                   cif.Y_in, cif.IR_in, cif.PC_in};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         5'd3, 5'd12: return {32'd0, a + b};
         5'd4:        return {32'd0, a - b};
         5'd5, 5'd13: return {32'd0, a & b};
         5'd6, 5'd14: return {32'd0, a | b};
         5'd15:       return (b == 32'd0) ? 64'd0 : {a % b, a / b};
         5'd16:       return {32'd0, a} * {32'd0, b};
         5'd17:       return {32'd0, -b};
         5'd18:       return {32'd0, ~b};
         default:     return 64'd0;
      endcase
   endfunction

   always_comb begin
      sel = 4'd0;
      if (cif.Gra)      sel = ir[26:23];
      else if (cif.Grb) sel = ir[22:19];
      else if (cif.Grc) sel = ir[18:15];
      bus_v = 32'd0;
      if (cif.PC_out)     bus_v = pc;
      if (cif.Zhigh_out)  bus_v = z[63:32];
      if (cif.Zlow_out)   bus_v = z[31:0];
      if (cif.HI_out)     bus_v = hi;
      if (cif.LO_out)     bus_v = lo;
      if (cif.MDR_out)    bus_v = mdr;
      if (cif.InPort_out) bus_v = IN_PORT;
      if (cif.C_out)      bus_v = {{13{ir[18]}}, ir[18:0]};
      if (cif.Rout)       bus_v = r[sel];
      if (cif.BAout)      bus_v = (sel == 4'd0) ? 32'd0 : r[sel];
   end

   always @(posedge clk) begin
      if (load_init) begin
         r <= r_init;  mem <= mem_init;
         pc <= '0; ir <= '0; mar <= '0; mdr <= '0; y <= '0; z <= '0;
         hi <= hi_init; lo <= lo_init;
      end else begin
         if (cif.PC_in)  pc  <= bus_v;
         if (cif.IR_in)  ir  <= bus_v;
         if (cif.Y_in)   y   <= bus_v;
         if (cif.Z_in)   z   <= cif.IncPC ? {32'd0, bus_v + 32'd1}
                                          : alu_f(cif.alu_instruction_bits, y, bus_v);
         if (cif.HI_in)  hi  <= bus_v;
         if (cif.LO_in)  lo  <= bus_v;
         if (cif.MAR_in) mar <= bus_v;
         if (cif.MDR_in) mdr <= cif.Read ? mem[mar[8:0]] : bus_v;
         if (cif.Write)  mem[mar[8:0]] <= mdr;
         if (cif.Rin)    r[sel] <= bus_v;
      end
   end

   // Expected control words of one instruction, fetch through last execute step
   task automatic push_instr(input logic [4:0] op);
      int o;
      o = int'(op);
      exp_q.push_back(F0); exp_q.push_back(F1); exp_q.push_back(F2);
      if (o >= 3 && o <= 14) begin
         exp_q.push_back(RUN | M_GRB | M_ROUT | M_Y_IN);
         exp_q.push_back(RUN | ((o <= 11) ? (M_GRC | M_ROUT) : M_C_OUT) | M_Z_IN | {1'b0, op, 26'd0});
         exp_q.push_back(RUN | M_ZLO_OUT | M_GRA | M_RIN);
      end else if (o == 17 || o == 18) begin
         exp_q.push_back(RUN | M_GRB | M_ROUT | M_Z_IN | {1'b0, op, 26'd0});
         exp_q.push_back(RUN | M_ZLO_OUT | M_GRA | M_RIN);
      end else if (o == 15 || o == 16) begin
         exp_q.push_back(RUN | M_GRA | M_ROUT | M_Y_IN);
         exp_q.push_back(RUN | M_GRB | M_ROUT | M_Z_IN | {1'b0, op, 26'd0});
         exp_q.push_back(RUN | M_ZLO_OUT | M_LO_IN);
         exp_q.push_back(RUN | M_ZHI_OUT | M_HI_IN);
      end else if (o <= 2) begin
         exp_q.push_back(RUN | M_GRB | M_BAOUT | M_Y_IN);
         exp_q.push_back(RUN | M_C_OUT | M_Z_IN | {1'b0, 5'd3, 26'd0});
         if (o == 1) begin
            exp_q.push_back(RUN | M_ZLO_OUT | M_GRA | M_RIN);
         end else begin
            exp_q.push_back(RUN | M_ZLO_OUT | M_MAR_IN);
            if (o == 0) begin
               exp_q.push_back(RUN | M_READ | M_MDR_IN);
               exp_q.push_back(RUN | M_MDR_OUT | M_GRA | M_RIN);
            end else begin
               exp_q.push_back(RUN | M_GRA | M_ROUT | M_MDR_IN);
               exp_q.push_back(RUN | M_WRITE);
            end
         end
      end else if (o == 22) exp_q.push_back(RUN | M_INP_OUT | M_GRA | M_RIN);
      else if (o == 23)     exp_q.push_back(RUN | M_GRA | M_ROUT | M_OUTP_IN);
      else if (o == 24)     exp_q.push_back(RUN | M_HI_OUT | M_GRA | M_RIN);
      else if (o == 25)     exp_q.push_back(RUN | M_LO_OUT | M_GRA | M_RIN);
      else                  exp_q.push_back(RUN);
   endtask

   task automatic clear_init();
      for (int i = 0; i < MEMW; i++) mem_init[i] = NOP_WORD;
      for (int i = 0; i < NREG; i++) r_init[i] = 32'd0;
      hi_init = 32'd0;
      lo_init = 32'd0;
   endtask

   task automatic setup_program();
      clr = 1'b1;
      load_init = 1'b1;
      @(posedge clk);
      #1 load_init = 1'b0;
      exp_q.delete();
   endtask

   // Steps one cycle per queued word; control word plus both invariants every cycle
   task automatic run_expected(input string tag);
      int cyc;
      int drivers;
      logic [W-1:0] e;
      cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         con_r = 1'($urandom_range(0, 1));
         e = exp_q.pop_front();
         checks++;
         if (obs_w !== e) begin
            errors++;
            $display("FAIL %s ctrl cycle %0d: got %h want %h", tag, cyc, obs_w, e);
         end
         checks++;
         if (cif.Read && cif.Write) begin
            errors++;
            $display("FAIL %s rw_excl cycle %0d: Read=1 Write=1 want not both", tag, cyc);
         end
         drivers = int'(cif.PC_out) + int'(cif.Zhigh_out) + int'(cif.Zlow_out) + int'(cif.HI_out)
                 + int'(cif.LO_out) + int'(cif.MDR_out) + int'(cif.InPort_out) + int'(cif.C_out)
                 + int'(cif.Rout | cif.BAout);
         checks++;
         if (drivers > 1) begin
            errors++;
            $display("FAIL %s bus_drv cycle %0d: drivers=%0d want <=1", tag, cyc, drivers);
         end
         cyc++;
      end
   endtask

   task automatic test_reset();
      clear_init();
      setup_program();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs_w !== RUN) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs_w, RUN);
         end
      end
      clr = 1'b0;
      exp_q.push_back(F0);
      run_expected("reset_release");
      clr = 1'b1;
   endtask

   task automatic test_mflo();
      clear_init();
      lo_init = 32'hF00F_F00F;
      mem_init[0] = 32'hCB00_0000;
      setup_program();
      @(negedge clk) clr = 1'b0;
      push_instr(5'd25);
      exp_q.push_back(F0);
      run_expected("mflo");
      checks++;
      if (r[6] !== 32'hF00F_F00F) begin
         errors++; $display("FAIL mflo_r6: got %h want f00ff00f", r[6]);
      end
      checks++;
      if (pc !== 32'd1) begin
         errors++; $display("FAIL mflo_pc: got %h want 1", pc);
      end
      clr = 1'b1;
   endtask

   task automatic test_add();
      clear_init();
      r_init[2] = 32'd5;
      r_init[4] = 32'd7;
      mem_init[0] = 32'h1A92_0000;
      setup_program();
      @(negedge clk) clr = 1'b0;
      push_instr(5'd3);
      exp_q.push_back(F0);
      run_expected("add");
      checks++;
      if (r[5] !== 32'd12) begin
         errors++; $display("FAIL add_r5: got %0d want 12", r[5]);
      end
      clr = 1'b1;
   endtask

   task automatic test_ld();
      clear_init();
      mem_init[0]     = 32'h0080_0055;
      mem_init[9'h55] = 32'h0000_0094;
      setup_program();
      @(negedge clk) clr = 1'b0;
      push_instr(5'd0);
      exp_q.push_back(F0);
      run_expected("ld");
      checks++;
      if (mar !== 32'h55) begin
         errors++; $display("FAIL ld_mar: got %h want 55", mar);
      end
      checks++;
      if (r[1] !== 32'h94) begin
         errors++; $display("FAIL ld_r1: got %h want 94", r[1]);
      end
      clr = 1'b1;
   endtask

   task automatic test_mul_halt();
      clear_init();
      r_init[3] = 32'h0001_0000;
      r_init[1] = 32'h0001_0000;
      mem_init[0] = 32'h8188_0000;
      mem_init[1] = 32'hD800_0000;
      setup_program();
      @(negedge clk) clr = 1'b0;
      push_instr(5'd16);
      push_instr(5'd27);
      for (int i = 0; i < 10; i++) exp_q.push_back(32'd0);
      run_expected("mul_halt");
      checks++;
      if (lo !== 32'd0 || hi !== 32'd1) begin
         errors++; $display("FAIL mul_hilo: got hi=%h lo=%h want hi=1 lo=0", hi, lo);
      end
      checks++;
      if (pc !== 32'd2) begin
         errors++; $display("FAIL halt_pc: got %h want 2", pc);
      end
      clr = 1'b1;
   endtask

   task automatic test_reset_mid_op();
      clear_init();
      r_init[2] = 32'd5;
      r_init[4] = 32'd7;
      r_init[5] = 32'h77;
      mem_init[0] = 32'h1A92_0000;
      setup_program();
      @(negedge clk) clr = 1'b0;
      push_instr(5'd3);
      void'(exp_q.pop_back());
      run_expected("abort_pre");
      #1 clr = 1'b1;
      #1;
      checks++;
      if (obs_w !== RUN) begin
         errors++; $display("FAIL abort_async: got %h want %h", obs_w, RUN);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (r[5] !== 32'h77) begin
         errors++; $display("FAIL abort_r5: got %h want 77", r[5]);
      end
      checks++;
      if (obs_w !== RUN) begin
         errors++; $display("FAIL abort_hold: got %h want %h", obs_w, RUN);
      end
      clr = 1'b0;
      exp_q.push_back(F0);
      run_expected("abort_restart");
      clr = 1'b1;
   endtask

   task automatic test_illegal();
      clear_init();
      for (int i = 0; i < NREG; i++) r_init[i] = $urandom();
      mem_init[0] = 32'hA000_0000;
      setup_program();
      @(negedge clk) clr = 1'b0;
      push_instr(5'd20);
      exp_q.push_back(F0);
      run_expected("illegal");
      for (int i = 0; i < NREG; i++) begin
         checks++;
         if (r[i] !== r_init[i]) begin
            errors++; $display("FAIL illegal_r%0d: got %h want %h", i, r[i], r_init[i]);
         end
      end
      checks++;
      if (pc !== 32'd1) begin
         errors++; $display("FAIL illegal_pc: got %h want 1", pc);
      end
      clr = 1'b1;
   endtask

   task automatic test_random();
      logic [4:0]  op;
      logic [31:0] fld;
      clear_init();
      for (int i = 0; i < NREG; i++) r_init[i] = $urandom();
      for (int i = 0; i < 40; i++) begin
         fld = $urandom();
         op  = 5'($urandom_range(0, 31));
         if (op == 5'd27) op = 5'd26;
         // Stores go to 0x100+ with base R0 so the program image is never overwritten
         if (op == 5'd2) begin
            fld[22:19] = 4'd0;
            fld[18:8]  = 11'd1;
         end
         mem_init[i] = {op, fld[26:0]};
      end
      setup_program();
      @(negedge clk) clr = 1'b0;
      for (int i = 0; i < 40; i++) push_instr(mem_init[i][31:27]);
      run_expected("random");
      clr = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clr = 1'b1;
      con_r = 1'b0;
      load_init = 1'b0;
      test_reset();
      test_mflo();
      test_add();
      test_ld();
      test_mul_halt();
      test_reset_mid_op();
      test_illegal();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end
endmodule
